// File: rtl/xbus_uart.sv
// Memory-mapped 8N1 UART slave on the xbus: TX FIFO + serializer, synchronized RX
// deserializer with a one-byte holding register. rdata is combinational (zero wait state).
//   state    | meaning
//   TX_IDLE  | line high, waiting for a FIFO entry
//   TX_START | start bit (txd=0)
//   TX_DATA  | 8 data bits, LSB first
//   TX_STOP  | stop bit; chains straight into TX_START when the FIFO is non-empty
//   RX_IDLE  | waiting for a falling edge
//   RX_START | half-bit wait, then re-check for a glitch
//   RX_DATA  | sampling 8 data bits every div clocks
//   RX_STOP  | sampling the stop bit
//   RX_WAIT  | framing error, waiting for the line to return high
module xbus_uart #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [15:0] DIV_RST   = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xbus_as,
  input  logic        xbus_we,
  input  logic [3:0]  xbus_be,
  input  logic [31:0] xbus_addr,
  input  logic [31:0] xbus_wdata,
  output logic [31:0] xbus_rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);
  localparam int unsigned AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic        sel, wr;
  logic [1:0]  reg_idx;
  logic        wr_rx, wr_st;
  logic        unused_bits;
  logic [15:0] div, div_eff;

  assign sel         = xbus_as & (xbus_addr[31:4] == BASE_ADDR[31:4]);
  assign wr          = sel & xbus_we;
  assign reg_idx     = xbus_addr[3:2];
  assign wr_rx       = wr & (reg_idx == 2'd1) & xbus_be[0];
  assign wr_st       = wr & (reg_idx == 2'd2) & xbus_be[0];
  assign unused_bits = ^{xbus_addr[1:0], xbus_wdata[31:16], xbus_be[3:2]};
  assign div_eff     = (div < 16'd2) ? 16'd2 : div;

  // TX FIFO: extra pointer MSB distinguishes full from empty
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        tx_empty, tx_full, push, push_ok, tx_pop;

  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = wr & (reg_idx == 2'd0) & xbus_be[0];
  assign push_ok  = push & ~tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= xbus_wdata[7:0];
  end

  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick, tx_busy;

  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) begin
                  tx_next = TX_START;
                  tx_pop  = 1'b1;
                end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) begin
                  if (!tx_empty) begin
                    tx_next = TX_START;
                    tx_pop  = 1'b1;
                  end else begin
                    tx_next = TX_IDLE;
                  end
                end
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Counter reloads from div at each bit boundary, so a new divisor takes effect next bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_pop) begin
      tx_cnt   <= div_eff - 16'd1;
      tx_bit   <= '0;
      tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
    end else if (tx_state != TX_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= div_eff - 16'd1;
        if (tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end
  end

  assign uart_txd = (tx_state == TX_START) ? 1'b0 :
                    (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  logic rx_s1, rx_s2, rx_prev, rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  rx_state_t   rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick, rx_done;

  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) begin
                  if (rx_s2) begin
                    rx_next = RX_IDLE;
                    rx_done = 1'b1;
                  end else begin
                    rx_next = RX_WAIT;
                  end
                end
      RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Idle keeps the half-bit count preloaded so START times from the detected edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_cnt <= (div_eff >> 1) - 16'd1;
      rx_bit <= '0;
    end else if (rx_tick) begin
      rx_cnt <= div_eff - 16'd1;
      if (rx_state == RX_DATA) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end else begin
      rx_cnt <= rx_cnt - 16'd1;
    end
  end

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ovr, tx_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= DIV_RST;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      if (wr && reg_idx == 2'd3) begin
        if (xbus_be[0]) div[7:0]  <= xbus_wdata[7:0];
        if (xbus_be[1]) div[15:8] <= xbus_wdata[15:8];
      end
      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (wr_rx) begin
        rx_valid <= 1'b0;
      end
      // A byte landing alongside a pop is not an overrun
      if (rx_done && rx_valid && !wr_rx)   rx_ovr <= 1'b1;
      else if (wr_st && xbus_wdata[4])     rx_ovr <= 1'b0;
      if (push && tx_full)                 tx_ovf <= 1'b1;
      else if (wr_st && xbus_wdata[5])     tx_ovf <= 1'b0;
    end
  end

  always_comb begin
    xbus_rdata = '0;
    if (sel) begin
      case (reg_idx)
        2'd1:    xbus_rdata = {23'b0, rx_valid, rx_byte};
        2'd2:    xbus_rdata = {26'b0, tx_ovf, rx_ovr, rx_valid, tx_busy, tx_full, tx_empty};
        2'd3:    xbus_rdata = {16'b0, div};
        default: xbus_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_xbus_uart.sv
// Directed bench for xbus_uart: register vector table plus TX/RX frame sequences.
module tb_xbus_uart;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_RX  = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] A_DIV = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        rst;
  logic        xbus_as, xbus_we;
  logic [3:0]  xbus_be;
  logic [31:0] xbus_addr, xbus_wdata, xbus_rdata;
  logic        uart_txd, uart_rxd;

  int n_vec = 0;
  int n_err = 0;

  xbus_uart #(.BASE_ADDR(BASE), .TX_DEPTH(4), .DIV_RST(16'd868)) dut (
    .clk(clk), .rst(rst), .xbus_as(xbus_as), .xbus_we(xbus_we), .xbus_be(xbus_be),
    .xbus_addr(xbus_addr), .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        as;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      xbus_as = vecs[i].as; xbus_we = vecs[i].we; xbus_be = vecs[i].be;
      xbus_addr = vecs[i].addr; xbus_wdata = vecs[i].wdata;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d", i), xbus_rdata, vecs[i].exp);
      @(posedge clk); #1;
      xbus_as = 1'b0; xbus_we = 1'b0; xbus_be = 4'h0;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    @(negedge clk);
    xbus_as = 1'b1; xbus_we = 1'b1; xbus_be = be; xbus_addr = addr; xbus_wdata = data;
    @(posedge clk); #1;
    xbus_as = 1'b0; xbus_we = 1'b0; xbus_be = 4'h0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    xbus_as = 1'b1; xbus_we = 1'b0; xbus_addr = addr;
    #1;
    check(name, xbus_rdata, exp);
    xbus_as = 1'b0;
  endtask

  task automatic sample_tx(input string tag, input logic exp_txd, input logic exp_busy,
                           output logic [31:0] st);
    @(negedge clk);
    xbus_as = 1'b1; xbus_we = 1'b0; xbus_addr = A_ST;
    #1;
    check({tag, "_txd"}, {31'b0, uart_txd}, {31'b0, exp_txd});
    check({tag, "_busy"}, {31'b0, xbus_rdata[2]}, {31'b0, exp_busy});
    st = xbus_rdata;
    xbus_as = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int d);
    @(negedge clk); uart_rxd = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (d) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (d) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0)      return 1'b0;
    else if (k >= 9) return 1'b1;
    else             return b[k-1];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  t2b[6];
    logic [31:0] st;
    logic        et;
    int          j, busy_cnt;

    vecs[0]  = '{1'b1, 1'b0, 4'h0, A_ST,  32'h0,         1'b1, 32'h0000_0001};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, A_RX,  32'h0,         1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, A_DIV, 32'h0,         1'b1, 32'h0000_0364};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, A_TX,  32'h0,         1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b0, 4'h0, 32'h2000_0008, 32'h0, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, A_ST,  32'h0,         1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b1, 4'h3, A_DIV, 32'h0000_1234, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, A_DIV, 32'h0,         1'b1, 32'h0000_1234};
    vecs[8]  = '{1'b1, 1'b1, 4'h1, A_DIV, 32'hFFFF_FF56, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, A_DIV, 32'h0,         1'b1, 32'h0000_1256};
    vecs[10] = '{1'b1, 1'b1, 4'h2, A_DIV, 32'h0000_AB00, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 4'h0, A_DIV, 32'h0,         1'b1, 32'h0000_AB56};
    vecs[12] = '{1'b1, 1'b1, 4'h0, A_DIV, 32'h0000_0000, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 4'h0, A_DIV, 32'h0,         1'b1, 32'h0000_AB56};
    vecs[14] = '{1'b1, 1'b1, 4'hF, 32'h2000_000C, 32'h7, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 4'h0, A_DIV, 32'h0,         1'b1, 32'h0000_AB56};
    vecs[16] = '{1'b1, 1'b1, 4'h3, A_DIV, 32'h0000_0004, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 4'h0, A_DIV, 32'h0,         1'b1, 32'h0000_0004};
    vecs[18] = '{1'b1, 1'b1, 4'h1, A_ST,  32'h0000_003F, 1'b0, 32'h0};
    vecs[19] = '{1'b1, 1'b0, 4'h0, A_ST,  32'h0,         1'b1, 32'h0000_0001};
    vecs[20] = '{1'b1, 1'b1, 4'h0, A_TX,  32'h0000_0055, 1'b0, 32'h0};
    vecs[21] = '{1'b1, 1'b0, 4'h0, A_ST,  32'h0,         1'b1, 32'h0000_0001};

    t2b[0] = 8'h5A; t2b[1] = 8'hC3; t2b[2] = 8'h0F;
    t2b[3] = 8'h81; t2b[4] = 8'h7E; t2b[5] = 8'hFF;

    rst = 1'b1; xbus_as = 1'b0; xbus_we = 1'b0; xbus_be = 4'h0;
    xbus_addr = '0; xbus_wdata = '0; uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    apply_vecs(0, 21);

    // Single A5 frame at div=4: one idle sample, 40 busy clocks, then idle
    bus_write(A_TX, 4'h1, 32'h0000_00A5);
    for (int i = 0; i < 44; i++) begin
      j  = i - 1;
      et = (j >= 0 && j < 40) ? fbit(8'hA5, j / 4) : 1'b1;
      sample_tx("t1", et, (j >= 0 && j < 40), st);
    end

    // Six pushes: byte 6 dropped, five contiguous frames
    for (int k = 0; k < 6; k++) bus_write(A_TX, 4'h1, {24'h0, t2b[k]});
    for (j = 4; j < 210; j++) begin
      if (j < 200) sample_tx("t2", fbit(t2b[j / 40], (j % 40) / 4), 1'b1, st);
      else         sample_tx("t2", 1'b1, 1'b0, st);
      if (j == 4) check("t2_status", st, 32'h0000_0026);
    end
    bus_write(A_ST, 4'h1, 32'h0000_0020);
    bus_read("t2_ovf_clr", A_ST, 32'h0000_0001);

    bus_write(A_DIV, 4'h3, 32'h0000_0008);
    send_rx(8'h3C, 1'b1, 8);
    bus_read("t3_rx", A_RX, 32'h0000_013C);
    bus_write(A_RX, 4'h1, 32'h0);
    bus_read("t3_pop", A_RX, 32'h0000_003C);
    bus_read("t3_st", A_ST, 32'h0000_0001);

    send_rx(8'h11, 1'b1, 8);
    send_rx(8'h22, 1'b1, 8);
    bus_read("t4_rx", A_RX, 32'h0000_0122);
    bus_read("t4_st", A_ST, 32'h0000_0019);
    bus_write(A_ST, 4'h1, 32'h0000_0010);
    bus_read("t4_ovr_clr", A_ST, 32'h0000_0009);
    bus_write(A_RX, 4'h1, 32'h0);
    bus_read("t4_pop", A_ST, 32'h0000_0001);

    @(negedge clk); uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
    bus_read("t5_glitch", A_ST, 32'h0000_0001);
    send_rx(8'h5A, 1'b1, 8);
    bus_read("t5_after_glitch", A_RX, 32'h0000_015A);
    bus_write(A_RX, 4'h1, 32'h0);
    send_rx(8'h77, 1'b0, 8);
    bus_read("t5_frame_st", A_ST, 32'h0000_0001);
    bus_read("t5_frame_rx", A_RX, 32'h0000_005A);
    send_rx(8'h96, 1'b1, 8);
    bus_read("t5_recover", A_RX, 32'h0000_0196);

    // div=1 behaves as 2: a frame lasts 20 clocks
    bus_write(A_DIV, 4'h3, 32'h0000_0001);
    bus_read("div1_rd", A_DIV, 32'h0000_0001);
    bus_write(A_TX, 4'h1, 32'h0000_00FF);
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      xbus_as = 1'b1; xbus_we = 1'b0; xbus_addr = A_ST;
      #1;
      if (xbus_rdata[2]) busy_cnt++;
      xbus_as = 1'b0;
    end
    check("div1_busy_clks", busy_cnt, 32'd20);

    // Reset in the middle of a frame with bytes queued and rx_valid set
    bus_write(A_DIV, 4'h3, 32'h0000_0004);
    bus_write(A_TX, 4'h1, 32'h0000_0000);
    bus_write(A_TX, 4'h1, 32'h0000_0011);
    bus_write(A_TX, 4'h1, 32'h0000_0022);
    repeat (9) @(negedge clk);
    #1;
    check("t6_txd_pre", {31'b0, uart_txd}, 32'h0);
    rst = 1'b1;
    #1;
    check("t6_txd_rst", {31'b0, uart_txd}, 32'h1);
    xbus_as = 1'b1; xbus_we = 1'b0; xbus_addr = A_ST;
    #1;
    check("t6_st_in_rst", xbus_rdata, 32'h0000_0001);
    xbus_as = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply_vecs(0, 5);
    repeat (10) @(negedge clk);
    #1;
    check("t6_txd_idle", {31'b0, uart_txd}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
